// File: rtl/seg7_display_interface.sv
// Four-digit multiplexed common-anode 7-segment driver.
// A load strobe captures a display word into a pending buffer. The pending
// buffer moves to the active buffer only at a frame boundary, so a frame
// never shows a mix of old and new digits. Each digit slot opens with a
// blanking interval that suppresses ghosting. All pins are active-low and
// registered.
module seg7_display_interface #(
  parameter int SCAN_DIV     = 50000, // cycles per digit slot; must exceed BLANK_CYCLES
  parameter int BLANK_CYCLES = 500    // dark cycles at the start of each slot; at least 1
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        iLoad,
  input  logic [15:0] iDigits,
  input  logic [3:0]  iDp,
  input  logic        iLzbEn,
  output logic [6:0]  oSeg,
  output logic        oDp,
  output logic [3:0]  oDigitSel,
  output logic        oFrameDone
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } state_t;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        lzb;
  } disp_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  disp_t         active_q, active_d;
  disp_t         pending_q, pending_d;
  logic          pend_flag_q, pend_flag_d;
  logic          frame_end;

  logic [6:0]    seg_d;
  logic          dp_d;
  logic [3:0]    sel_d;
  logic [3:0]    nibble;
  logic [3:0]    blank;

  // Hex glyphs, active-low {g,f,e,d,c,b,a}; b and d are lowercase.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Slot timing: the counter sweeps the blank part, then the drive part, then
  // advances the digit index. A wrap from digit 3 marks the frame boundary.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through this block
    // leaves a value held, and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    idx_d     = idx_q;
    frame_end = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d     = '0;
      state_d   = ST_BLANK;
      idx_d     = idx_q + 2'd1;
      frame_end = (idx_q == 2'd3);
    end else if (cnt_q == BLANK_LAST) begin
      state_d = ST_DRIVE;
    end
  end

  // Double buffering: pending moves to active at the boundary. A load in the
  // same cycle is kept in pending for the next boundary.
  always_comb begin
    active_d    = active_q;
    pending_d   = pending_q;
    pend_flag_d = pend_flag_q;
    if (frame_end && pend_flag_q) begin
      active_d    = pending_q;
      pend_flag_d = 1'b0;
    end
    if (iLoad) begin
      pending_d   = '{digits: iDigits, dp: iDp, lzb: iLzbEn};
      pend_flag_d = 1'b1;
    end
  end

  // Output decode from the next-cycle state, so the registered pins match the
  // slot that the state registers hold in that same cycle.
  always_comb begin
    nibble   = active_d.digits[{idx_d, 2'b00} +: 4];
    blank[3] = active_d.lzb && (active_d.digits[15:12] == 4'h0);
    blank[2] = blank[3] && (active_d.digits[11:8] == 4'h0);
    blank[1] = blank[2] && (active_d.digits[7:4] == 4'h0);
    blank[0] = 1'b0;
    seg_d    = 7'h7F;
    dp_d     = 1'b1;
    sel_d    = 4'hF;
    if (state_d == ST_DRIVE) begin
      sel_d = ~(4'b0001 << idx_d);
      dp_d  = ~active_d.dp[idx_d];
      seg_d = blank[idx_d] ? 7'h7F : decode(nibble);
    end
  end

  // Scan state and display buffers.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples values from before the edge, whatever the statement order.
    if (!RESETn) begin
      state_q     <= ST_BLANK;
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      // NOTE: the buffers are ordinary registers, not a memory, and they are
      // reset. After reset the display shows 0000 and any stale load is lost.
      active_q    <= '0;
      pending_q   <= '0;
      pend_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      pend_flag_q <= pend_flag_d;
    end
  end

  // Registered, glitch-free pins.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      oSeg       <= 7'h7F;
      oDp        <= 1'b1;
      oDigitSel  <= 4'hF;
      oFrameDone <= 1'b0;
    end else begin
      oSeg       <= seg_d;
      oDp        <= dp_d;
      oDigitSel  <= sel_d;
      oFrameDone <= frame_end;
    end
  end

endmodule
